// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one registered 4-bit ALU core among
// NUM_REQ requesters, with per-requester command and response handshakes.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ALU_LATENCY = 1,
  parameter logic [3:0]  MAX_OP      = 4'h9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  input  logic [4*NUM_REQ-1:0]   req_op,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [3:0]             alu_op,
  input  logic [7:0]             alu_result,
  input  logic                   alu_carry,
  input  logic                   alu_ovf,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [7:0]             rsp_data,
  output logic [2:0]             rsp_flags,
  output logic                   busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_grant, cur, grant;
  logic             grant_vld;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       sel_a, sel_b, sel_op;
  logic             rsp_ready_cur;
  logic             accept;
  logic             illegal;

  // Rotating search starting just above last_grant; the sum never exceeds
  // 2*NUM_REQ-1, so one conditional subtract implements the wrap.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(last_grant) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_vld && req_valid[cand[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_a         = '0;
    sel_b         = '0;
    sel_op        = '0;
    rsp_ready_cur = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant == IDX_W'(i)) begin
        sel_a  = req_a[4*i +: 4];
        sel_b  = req_b[4*i +: 4];
        sel_op = req_op[4*i +: 4];
      end
      if (cur == IDX_W'(i)) rsp_ready_cur = rsp_ready[i];
    end
  end

  // rst_n gates the combinational ready so nothing is offered during reset.
  assign accept  = rst_n && (state_q == IDLE) && grant_vld;
  assign illegal = (sel_op > MAX_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = illegal ? RESP : EXEC;
      EXEC:    if (cnt == '0) state_d = RESP;
      RESP:    if (rsp_ready_cur) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_q != IDLE);
    if (accept) req_ready[grant] = 1'b1;
    if (state_q == RESP) rsp_valid[cur] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      cnt        <= '0;
      cur        <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      rsp_data   <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cur <= grant;
            if (illegal) begin
              rsp_data  <= '0;
              rsp_flags <= 3'b100;
            end else begin
              alu_a  <= sel_a;
              alu_b  <= sel_b;
              alu_op <= sel_op;
              cnt    <= CNT_W'(ALU_LATENCY);
            end
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_data  <= alu_result;
            rsp_flags <= {1'b0, alu_ovf, alu_carry};
          end
        end
        RESP: begin
          if (rsp_ready_cur) last_grant <= cur;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: expected responses are queued at issue
// time and a negedge monitor pops and compares them at each response handshake.
module tb_alu_share_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default latency)
  logic            rst_n;
  logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4*NR-1:0] req_a, req_b, req_op;
  logic [3:0]      alu_a, alu_b, alu_op;
  logic [7:0]      alu_result, rsp_data;
  logic            alu_carry, alu_ovf, busy;
  logic [2:0]      rsp_flags;

  // second instance with a three-stage ALU, used for the reset-in-EXEC case
  logic            r_rst_n;
  logic [NR-1:0]   r_req_valid, r_req_ready, r_rsp_valid, r_rsp_ready;
  logic [4*NR-1:0] r_req_a, r_req_b, r_req_op;
  logic [3:0]      r_alu_a, r_alu_b, r_alu_op;
  logic [7:0]      r_alu_result, r_rsp_data;
  logic            r_alu_carry, r_alu_ovf, r_busy;
  logic [2:0]      r_rsp_flags;

  alu_share_arbiter #(.NUM_REQ(NR), .ALU_LATENCY(LAT), .MAX_OP(4'h9)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  alu_share_arbiter #(.NUM_REQ(NR), .ALU_LATENCY(LAT3), .MAX_OP(4'h9)) dut3 (
    .clk(clk), .rst_n(r_rst_n), .req_valid(r_req_valid), .req_ready(r_req_ready),
    .req_a(r_req_a), .req_b(r_req_b), .req_op(r_req_op),
    .alu_a(r_alu_a), .alu_b(r_alu_b), .alu_op(r_alu_op),
    .alu_result(r_alu_result), .alu_carry(r_alu_carry), .alu_ovf(r_alu_ovf),
    .rsp_valid(r_rsp_valid), .rsp_ready(r_rsp_ready), .rsp_data(r_rsp_data),
    .rsp_flags(r_rsp_flags), .busy(r_busy)
  );

  // ALU core stand-in: returns {ovf, carry, result[7:0]}
  function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    logic [4:0] s;
    logic [7:0] r;
    logic       c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin
        s = {1'b0, a} + {1'b0, b};
        r = {3'b000, s};
        c = s[4];
        v = (a[3] == b[3]) && (s[3] != a[3]);
      end
      4'h1: begin
        s = {1'b0, a} - {1'b0, b};
        r = {4'h0, s[3:0]};
        c = s[4];
        v = (a[3] != b[3]) && (s[3] != a[3]);
      end
      4'h2: r = {4'h0, a} * {4'h0, b};
      4'h3: if (b != 4'h0) r = {a % b, a / b};
      default: r = {4'h0, a & b};
    endcase
    return {v, c, r};
  endfunction

  logic [9:0] pipe  [LAT];
  logic [9:0] pipe3 [LAT3];
  always @(posedge clk) begin
    pipe[0] <= alu_f(alu_op, alu_a, alu_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    pipe3[0] <= alu_f(r_alu_op, r_alu_a, r_alu_b);
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign {alu_ovf, alu_carry, alu_result}       = pipe[LAT-1];
  assign {r_alu_ovf, r_alu_carry, r_alu_result} = pipe3[LAT3-1];

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
    logic [2:0] flags;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // monitor: protocol invariants every cycle, scoreboard pop on each handshake
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(req_ready) || !$onehot0(rsp_valid) || ((|req_ready) && (|rsp_valid))) begin
        errors++;
        $display("FAIL protocol: req_ready=%b rsp_valid=%b, required one-hot-or-zero and disjoint",
                 req_ready, rsp_valid);
      end
      if (|(rsp_valid & rsp_ready)) begin
        exp_t e;
        logic [2:0] got_idx;
        got_idx = '0;
        for (int i = 0; i < NR; i++) if (rsp_valid[i]) got_idx = 3'(i);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got idx=%0d data=0x%0h, expected no response",
                   got_idx, rsp_data);
        end else begin
          e = sb.pop_front();
          if (got_idx !== e.idx || rsp_data !== e.data || rsp_flags !== e.flags) begin
            errors++;
            $display("FAIL rsp: got idx=%0d data=0x%0h flags=%b, expected idx=%0d data=0x%0h flags=%b",
                     got_idx, rsp_data, rsp_flags, e.idx, e.data, e.flags);
          end
        end
      end
    end
  end

  task automatic wait_accept(input int idx);
    bit seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (req_ready[idx]) seen = 1'b1;
    end
    if (!seen) timeout("accept");
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic issue(input int idx, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic [7:0] d, input logic [2:0] f);
    exp_t e;
    e.idx = 3'(idx); e.data = d; e.flags = f;
    sb.push_back(e);
    req_a[4*idx +: 4]  = a;
    req_b[4*idx +: 4]  = b;
    req_op[4*idx +: 4] = op;
    req_valid[idx]     = 1'b1;
    wait_accept(idx);
  endtask

  // n = number of negedge samples until rsp_valid[idx] is seen
  task automatic wait_rsp(input int idx, output int n);
    bit seen = 1'b0;
    n = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      n++;
      if (rsp_valid[idx]) seen = 1'b1;
    end
    if (!seen) timeout("rsp_valid");
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) timeout("drain");
    @(posedge clk); #1;
  endtask

  task automatic r_accept(input int idx);
    bit seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (r_req_ready[idx]) seen = 1'b1;
    end
    if (!seen) timeout("r_accept");
    @(posedge clk); #1;
    r_req_valid = '0;
  endtask

  task automatic r_wait_rsp(input int idx);
    bit seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (r_rsp_valid[idx]) seen = 1'b1;
    end
    if (!seen) timeout("r_rsp_valid");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; r_rst_n = 1'b0;
    req_valid = '1; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '1;
    r_req_valid = '0; r_req_a = '0; r_req_b = '0; r_req_op = '0; r_rsp_ready = '1;
    repeat (2) @(posedge clk);
    #2;
    // reset state, with every requester asserting valid
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp", {21'b0, rsp_data, rsp_flags}, 0);
    chk("rst_alu", {20'b0, alu_a, alu_b, alu_op}, 0);
    chk("rst_busy", 32'(busy), 0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1; r_rst_n = 1'b1;

    // all four MUL F*F held valid: grants 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      exp_t e;
      e.idx = 3'(k % 4); e.data = 8'hE1; e.flags = 3'b000;
      sb.push_back(e);
    end
    req_a = {4{4'hF}}; req_b = {4{4'hF}}; req_op = {4{4'h2}};
    req_valid = '1;
    begin
      int acc = 0;
      for (int t = 0; t < 200 && acc < 5; t++) begin
        @(negedge clk);
        if (|req_ready) begin
          acc++;
          if (acc == 5) begin
            @(posedge clk); #1;
            req_valid = '0;
          end
        end
      end
      if (acc < 5) begin
        timeout("rr_accepts");
        req_valid = '0;
      end
    end
    wait_drain();

    // single ADD 3+5 from requester 2
    issue(2, 4'h3, 4'h5, 4'h0, 8'h08, 3'b010);
    @(negedge clk);
    chk("t1_ready_pulse", 32'(req_ready), 0);
    wait_rsp(2, n);
    chk("t1_edges_to_rsp", n, LAT + 1);  // first explicit sample was one edge after accept
    wait_drain();

    // backpressure on requester 1, requester 0 waiting meanwhile
    rsp_ready = 4'b1101;
    issue(1, 4'hF, 4'h2, 4'h0, 8'h11, 3'b001);
    begin
      exp_t e;
      e.idx = 3'd0; e.data = 8'h02; e.flags = 3'b000;
      sb.push_back(e);
    end
    req_a[3:0] = 4'h1; req_b[3:0] = 4'h1; req_op[3:0] = 4'h0;
    req_valid[0] = 1'b1;
    wait_rsp(1, n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {15'b0, rsp_valid, rsp_data, rsp_flags, busy, req_ready},
          {15'b0, 4'b0010, 8'h11, 3'b001, 1'b1, 4'b0000});
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    @(negedge clk);
    chk("bp_last_valid", 32'(rsp_valid), 32'b0010);
    @(negedge clk);
    chk("bp_done_next_grant", {24'b0, rsp_valid, req_ready}, {24'b0, 4'b0000, 4'b0001});
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_drain();

    // DIV by zero, then 9/2 -> {rem=1, quot=4}
    issue(0, 4'h9, 4'h0, 4'h3, 8'h00, 3'b000);
    wait_drain();
    issue(0, 4'h9, 4'h2, 4'h3, 8'h14, 3'b000);
    wait_drain();

    // illegal opcode: response next cycle, ALU inputs keep the DIV 9/2
    issue(1, 4'h2, 4'h3, 4'hC, 8'h00, 3'b100);
    wait_rsp(1, n);
    chk("ill_rsp_cycle_after", n, 1);
    chk("ill_alu_hold", {20'b0, alu_a, alu_b, alu_op}, {20'b0, 4'h9, 4'h2, 4'h3});
    wait_drain();

    // three-stage instance: complete one ADD, then reset mid-EXEC
    r_req_a[11:8] = 4'h3; r_req_b[11:8] = 4'h5; r_req_op[11:8] = 4'h0;
    r_req_valid[2] = 1'b1;
    r_accept(2);
    r_wait_rsp(2);
    chk("r_add", {21'b0, r_rsp_data, r_rsp_flags}, {21'b0, 8'h08, 3'b010});
    @(posedge clk); #1;
    r_req_a[7:4] = 4'hF; r_req_b[7:4] = 4'hF; r_req_op[7:4] = 4'h2;
    r_req_valid[1] = 1'b1;
    r_accept(1);
    @(negedge clk);
    @(negedge clk);
    chk("r_busy_exec", {31'b0, r_busy}, 1);
    r_rst_n = 1'b0;
    #1;
    chk("r_rst_alu", {20'b0, r_alu_a, r_alu_b, r_alu_op}, 0);
    chk("r_rst_rsp", {21'b0, r_rsp_data, r_rsp_flags}, 0);
    chk("r_rst_hs", {23'b0, r_busy, r_req_ready, r_rsp_valid}, 0);
    @(posedge clk); @(posedge clk); #1;
    r_rst_n = 1'b1;
    r_req_a[3:0] = 4'h1; r_req_b[3:0] = 4'h1; r_req_op[3:0] = 4'h0;
    r_req_a[15:12] = 4'h2; r_req_b[15:12] = 4'h2; r_req_op[15:12] = 4'h0;
    r_req_valid = 4'b1001;
    @(negedge clk);
    chk("r_after_rst_grant", {24'b0, r_req_ready, r_rsp_valid}, {24'b0, 4'b0001, 4'b0000});
    @(posedge clk); #1;
    r_req_valid = '0;
    r_wait_rsp(0);
    chk("r_req0_rsp", {17'b0, r_rsp_valid, r_rsp_data, r_rsp_flags},
        {17'b0, 4'b0001, 8'h02, 3'b000});

    repeat (3) @(posedge clk);
    if (sb.size() != 0) timeout("final_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
